cbg_lsu_responder: RTL and testbench

Responder end of the LSU<->CBG interface: one instance per PE row. It accepts packed load/store requests from the row's LSU on the LSU-to-CBG bus, buffers them in a small request FIFO and serves them from a local single-port data bank. Read data returns on the CBG-to-LSU bus. A host port shares the bank for preload and readback, arbitrated against LSU traffic by a starvation-guarded FSM.

---
 rtl/cbg_lsu_responder.sv | 109 ++++++++++
 tb/tb_cbg_lsu_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbg_lsu_responder.sv
// cbg_lsu_responder: per-row LSU request FIFO and data bank with a host port,
// arbitrated by a starvation-guarded FSM (one bank access per cycle).
module cbg_lsu_responder #(
    parameter int AW           = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int L_W          = AW + 34,
    parameter int C_W          = 34
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [L_W-1:0] lsu_to_cbg_bus,
    output logic [C_W-1:0] cbg_to_lsu_bus,
    input  logic           host_req,
    input  logic           host_we,
    input  logic [AW-1:0]  host_addr,
    input  logic [31:0]    host_wdata,
    output logic           host_gnt,
    output logic           host_rvalid,
    output logic [31:0]    host_rdata,
    output logic           busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, LSU, HOST} state_t;

    logic          req_valid, req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    assign {req_valid, req_we, req_addr, req_wdata} = lsu_to_cbg_bus;

    logic [AW+32:0] fifo_mem [FIFO_DEPTH];
    logic [31:0]    bank [2**AW];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d, starve_inc;
    state_t        state_q, state_d;
    logic          rsp_valid_q, host_rvalid_q;
    logic [31:0]   rsp_rdata_q, host_rdata_q;

    logic          req_ready, push, pop, fifo_ne, starved;
    logic          head_we, bank_we;
    logic [AW-1:0] head_addr, bank_addr;
    logic [31:0]   head_wdata, bank_wdata;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign req_ready = count_q < CW'(FIFO_DEPTH);
    assign push      = req_valid && req_ready;
    assign fifo_ne   = count_q != '0;
    assign pop       = state_q == LSU && fifo_ne;
    assign host_gnt  = state_q == HOST && host_req;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    assign {head_we, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

    assign bank_addr  = pop ? head_addr : host_addr;
    assign bank_we    = pop ? head_we : host_gnt && host_we;
    assign bank_wdata = pop ? head_wdata : host_wdata;

    assign starve_inc = fifo_ne ? starve_q + 1'b1 : '0;
    assign starved    = starve_inc >= SW'(STARVE_LIMIT);

    // Looking at count_d lets a request accepted this cycle be popped next cycle.
    always_comb begin
        state_d  = host_req ? HOST : count_d != '0 ? LSU : IDLE;
        starve_d = '0;
        if (state_q == HOST && host_req) begin
            state_d  = starved ? LSU : HOST;
            starve_d = starved ? '0 : starve_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            host_rvalid_q <= 1'b0;
            rsp_rdata_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            count_q       <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            rsp_valid_q   <= pop && !head_we;
            host_rvalid_q <= host_gnt && !host_we;
            if (pop && !head_we) rsp_rdata_q <= bank[bank_addr];
            if (host_gnt && !host_we) host_rdata_q <= bank[bank_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {req_we, req_addr, req_wdata};
        if (bank_we) bank[bank_addr] <= bank_wdata;
    end

    assign cbg_to_lsu_bus = {rsp_valid_q, req_ready, rsp_rdata_q};
    assign host_rvalid    = host_rvalid_q;
    assign host_rdata     = host_rdata_q;
    assign busy           = fifo_ne || rsp_valid_q;
endmodule

// File: tb/tb_cbg_lsu_responder.sv
// tb_cbg_lsu_responder: directed scenario bench for cbg_lsu_responder.
module tb_cbg_lsu_responder;
    localparam int AW  = 8;
    localparam int L_W = AW + 34;
    localparam int C_W = 34;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [L_W-1:0] lsu_bus = '0;
    logic [C_W-1:0] cbg;
    logic           host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0]  host_addr = '0;
    logic [31:0]    host_wdata = '0;
    logic           host_gnt, host_rvalid, busy;
    logic [31:0]    host_rdata;
    int             n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cbg_lsu_responder dut (
        .clk(clk), .rst(rst), .lsu_to_cbg_bus(lsu_bus), .cbg_to_lsu_bus(cbg),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .busy(busy)
    );

    function automatic logic [L_W-1:0] lreq(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        return {1'b1, we, a, d};
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'hCAFE0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        lsu_bus = lreq(1'b0, 8'd1, 32'h0);
        host_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if ({cbg, host_gnt, busy, host_rvalid} !== {2'b01, 32'h0, 3'b000}) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: bus=%h gnt=%b busy=%b rv=%b, want bus=100000000 gnt=0 busy=0 rv=0",
                         i, cbg, host_gnt, busy, host_rvalid);
            end
            tick();
        end
        lsu_bus = '0;
        host_req = 1'b0;
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_host_preload();
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b0) begin n_fail++; $display("FAIL preload_idle_gnt: got %b want 0", host_gnt); end
        tick();
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL preload_gnt: got %b want 1", host_gnt); end
        tick();
        host_req = 1'b0;
        lsu_bus = lreq(1'b0, 8'd5, 32'h0);
        @(negedge clk);
        n_chk++;
        if ({cbg[32], host_gnt} !== 2'b10) begin n_fail++; $display("FAIL preload_accept: rdy/gnt=%b want 10", {cbg[32], host_gnt}); end
        tick();
        lsu_bus = '0;
        @(negedge clk);
        n_chk++;
        if (cbg[33] !== 1'b0) begin n_fail++; $display("FAIL preload_t1: rsp_valid=%b want 0", cbg[33]); end
        tick();
        @(negedge clk);
        n_chk++;
        if ({cbg[33], cbg[31:0]} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL preload_t2: valid=%b rdata=%h want 1 deadbeef", cbg[33], cbg[31:0]);
        end
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
        @(negedge clk);
        n_chk++;
        if ({cbg, host_gnt} !== {2'b01, 32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("FAIL preload_hold: bus=%h gnt=%b want 1deadbeef 0", cbg, host_gnt);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if ({host_gnt, host_rvalid} !== 2'b10) begin n_fail++; $display("FAIL host_read_gnt: gnt/rv=%b want 10", {host_gnt, host_rvalid}); end
        tick();
        host_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({host_rvalid, host_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL host_rdata: rv=%b data=%h want 1 deadbeef", host_rvalid, host_rdata);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if ({host_rvalid, host_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL host_rdata_hold: rv=%b data=%h want 0 deadbeef", host_rvalid, host_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses = 0, idx = -1;
        logic [31:0] data = '0;
        for (int i = 0; i < 7; i++) begin
            lsu_bus = i == 0 ? lreq(1'b1, 8'd3, 32'h1234) : i == 1 ? lreq(1'b0, 8'd3, 32'h0) : '0;
            @(negedge clk);
            if (i < 2) begin
                n_chk++;
                if (cbg[32] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, cbg[32]); end
            end
            if (i == 1) begin
                n_chk++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
            end
            if (cbg[33]) begin pulses++; idx = i; data = cbg[31:0]; end
            tick();
        end
        n_chk++;
        if (pulses !== 1 || idx !== 3 || data !== 32'h1234) begin
            n_fail++; $display("FAIL b2b_rsp: pulses=%0d cycle=%0d data=%h want 1 3 00001234", pulses, idx, data);
        end
    endtask

    task automatic preload_bank();
        int i = 0;
        for (int c = 0; c < 100 && i < 32; c++) begin
            host_req = 1'b1; host_we = 1'b1; host_addr = AW'(i); host_wdata = pat(i);
            @(negedge clk);
            if (host_gnt) i++;
            tick();
        end
        host_req = 1'b0; host_we = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int sent = 0, nrsp = 0, first_acc = -1, first_rsp = -1, grants = 0, acc_before = 0;
        logic [31:0] got [6];
        for (int cyc = 0; cyc < 300 && nrsp < 6; cyc++) begin
            lsu_bus = sent < 6 ? lreq(1'b0, AW'(10 + sent), 32'h0) : '0;
            host_req = nrsp < 4; host_we = 1'b0; host_addr = 8'd31;
            @(negedge clk);
            if (cbg[33]) begin
                if (first_rsp < 0) first_rsp = cyc;
                got[nrsp] = cbg[31:0];
                nrsp++;
            end
            if (first_acc >= 0 && cyc > first_acc && first_rsp < 0 && host_gnt) grants++;
            if (sent == 4 && first_rsp < 0) begin
                n_chk++;
                if (cbg[32] !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready cyc%0d: got %b want 0", cyc, cbg[32]); end
            end
            if (lsu_bus[L_W-1] && cbg[32]) begin
                if (first_acc < 0) first_acc = cyc;
                if (first_rsp < 0) acc_before++;
                sent++;
            end
            tick();
        end
        lsu_bus = '0; host_req = 1'b0;
        n_chk++;
        if (nrsp !== 6) begin n_fail++; $display("FAIL bp_rsp_count: got %0d want 6", nrsp); end
        n_chk++;
        if (grants !== 8) begin n_fail++; $display("FAIL bp_starve_grants: got %0d want 8", grants); end
        n_chk++;
        if (acc_before !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc_before); end
        for (int k = 0; k < nrsp && k < 6; k++) begin
            n_chk++;
            if (got[k] !== pat(10 + k)) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", k, got[k], pat(10 + k)); end
        end
        tick();
        tick();
    endtask

    task automatic test_wrap();
        int sent = 0, nrsp = 0;
        logic [31:0] got [16];
        host_req = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            lsu_bus = sent < 12 ? lreq(1'b0, AW'(sent), 32'h0) : '0;
            @(negedge clk);
            if (cbg[33]) begin
                if (nrsp < 16) got[nrsp] = cbg[31:0];
                nrsp++;
            end
            if (lsu_bus[L_W-1] && cbg[32]) sent++;
            tick();
        end
        lsu_bus = '0;
        n_chk++;
        if (sent !== 12 || nrsp !== 12) begin n_fail++; $display("FAIL wrap_count: sent=%0d rsp=%0d want 12 12", sent, nrsp); end
        for (int k = 0; k < nrsp && k < 12; k++) begin
            n_chk++;
            if (got[k] !== pat(k)) begin n_fail++; $display("FAIL wrap_data%0d: got %h want %h", k, got[k], pat(k)); end
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0, busy_seen = 0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd31;
        for (int i = 0; i < 3; i++) begin
            lsu_bus = lreq(1'b0, AW'(20 + i), 32'h0);
            @(negedge clk);
            n_chk++;
            if (cbg[32] !== 1'b1) begin n_fail++; $display("FAIL ar_accept%0d: ready=%b want 1", i, cbg[32]); end
            tick();
        end
        lsu_bus = '0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_before: got %b want 1", busy); end
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if ({cbg, busy} !== {2'b01, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL ar_in_reset: bus=%h busy=%b want 100000000 0", cbg, busy);
        end
        tick();
        tick();
        host_req = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++;
        if (cbg[32] !== 1'b1) begin n_fail++; $display("FAIL ar_ready_release: got %b want 1", cbg[32]); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cbg[33]) pulses++;
            if (busy) busy_seen++;
            tick();
        end
        n_chk++;
        if (pulses !== 0 || busy_seen !== 0) begin
            n_fail++; $display("FAIL ar_flush: rsp_pulses=%0d busy_cycles=%0d want 0 0", pulses, busy_seen);
        end
    endtask

    initial begin
        test_reset();
        test_host_preload();
        test_back_to_back();
        preload_bank();
        test_backpressure();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
